fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode/controller stage; sole producer of the 32-bit instruction word the decoder consumes.
- Owns the PC and issues word reads to instruction memory over a valid/ready request channel with in-order, variable-latency responses.
- Buffers returned words with their PCs in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts redirects (taken branch, JAL, JALR) from execute and squashes all wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, FIFO entries; also the maximum number of outstanding imem requests (power of two, ≥2).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_resp_valid  in  1  response word valid; always accepted, in request order.
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  taken control transfer from execute.
- redirect_pc  in  32  redirect target.
- inst_valid  out  1  inst_out/pc_out valid to decode.
- inst_ready  in  1  decode consumes this cycle.
- inst_out  out  32  instruction word to decode.
- pc_out  out  32  PC of inst_out.

Behaviour:
- Reset (synchronous, active-high) values:
  - fetch_pc = RESET_PC.
  - FIFO empty; outstanding = 0; discard = 0.
  - imem_req_valid = 0 in the reset cycle.
  - inst_valid = 0; inst_out = 32'h0000_0013 (NOP); pc_out = RESET_PC.
- Issue:
  - imem_req_valid = !rst && !redirect_valid && (fifo_count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - On valid&ready: fetch_pc += 4 (mod 2^32; wraps silently); outstanding += 1.
- Response:
  - Each imem_resp_valid decrements outstanding.
  - If discard > 0: the word is dropped and discard is decremented.
  - Otherwise the word is pushed into the FIFO with its PC. Each entry's PC comes from a per-request PC queue, or equivalently from the PC of the oldest live request.
  - A credit always exists for the push, so overflow is impossible; the bench asserts this.
- Output:
  - FIFO head drives inst_out and pc_out; inst_valid = FIFO non-empty.
  - Pop on inst_valid && inst_ready.
  - No combinational path from imem_resp to inst_out. Minimum latency is request handshake in cycle N, response in cycle N+k, inst_valid in cycle N+k+1.
- Redirect (priority over everything except rst):
  - FIFO is flushed and any pop in that cycle is ignored; inst_valid = 0 the following cycle.
  - fetch_pc = redirect_pc.
  - discard = outstanding_after_this_cycle: the old discard plus live requests not yet answered, excluding any response consumed in this same cycle. That response is itself dropped.
  - No request is issued in the redirect cycle; the first request to redirect_pc issues in the next cycle.
- Back-to-back redirects: each one re-flushes and re-targets; the latest target wins. Discard accumulates correctly because no new requests issue during redirect cycles.
- Decode stall (inst_ready = 0): the FIFO fills and issue stops when count + outstanding = DEPTH. Nothing is lost.
- Reset mid-operation: state clears. Responses to pre-reset requests must not arrive after reset; the memory is reset on the same rst.

Optional Feature:
- FETCH_MISALIGN_CHK_EN:
  - Defined: adds output port inst_misalign (1 bit). A redirect with redirect_pc[1:0] != 0 forces fetch_pc[1:0] to 0 and makes the next FIFO entry carry a misalign flag. That entry is presented with inst_out = NOP and inst_misalign = 1 and is popped normally.
  - Undefined: the port is absent and redirect_pc[1:0] is ignored (treated as 0).

Decomposition:
- Shared package/header, alongside the existing opcode/control definitions: NOP encoding 32'h0000_0013, RESET_PC default, instruction width 32.
- One sub-module, fetch_fifo:
  - Parameterised DEPTH × (32 inst + 32 pc [+1 misalign]).
  - Ports: push, pop, flush, count, head.
  - Synchronous flush; flush has priority over push and pop.

Test Plan:
- Reset, then imem ready always with latency 1 → requests to 0x0, 0x4, 0x8…; inst_out 0x00500093 at pc_out 0x0 appears in the cycle after its response; one instruction per cycle sustained.
- inst_ready held 0 for 10 cycles with DEPTH=2 → exactly 2 requests issued, FIFO holds pc 0x0 and 0x4, no third request; releasing inst_ready drains in order.
- Redirect to 0x100 with 2 requests outstanding → both late responses dropped; next inst_valid carries pc_out 0x100; no stale PC ever reaches decode.
- Redirect in the same cycle as a response and a decode pop → response dropped, pop ignored, discard equals remaining outstanding; first post-redirect request is 0x100.
- Two consecutive redirects (0x200, then 0x300) → only 0x300-stream instructions are delivered.
- With FETCH_MISALIGN_CHK_EN, redirect to 0x102 → entry with pc_out 0x100, inst_out NOP, inst_misalign = 1; without the macro → normal fetch from 0x100.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: instruction width, NOP encoding,
// default reset PC and the FIFO entry layout.
// Optional feature macro: FETCH_MISALIGN_CHK_EN adds a misalign flag to each entry.
package fetch_stage_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
`ifdef FETCH_MISALIGN_CHK_EN
    logic              misalign;
`endif
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fifo_entry_t;

  // Clear the byte offset so every fetch address is a word address.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between memory responses and decode.
// DEPTH entries (power of two), synchronous flush with priority over push/pop.
// Optional feature macro: FETCH_MISALIGN_CHK_EN widens each entry by a misalign bit.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  fifo_entry_t                  push_entry,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fifo_entry_t                  head
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  // Entry storage; slot contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers and occupancy; a flush leaves the buffer exactly as reset does.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction
// memory, buffers in-order responses and hands them to decode. Redirects
// from execute flush the buffer and mark every in-flight response for discard.
// Optional feature macro: FETCH_MISALIGN_CHK_EN adds the inst_misalign output.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic        inst_misalign,
`endif
  output logic [31:0] pc_out
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] OCC_MAX = (CNT_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [31:0]      target_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  logic             req_fire;
  logic             resp_keep;
  logic             fifo_pop;
  fifo_entry_t      push_entry;
  fifo_entry_t      head;

  assign target_pc = align_word(redirect_pc);

`ifdef FETCH_MISALIGN_CHK_EN
  logic mis_pend;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  // Credit check: buffered words plus in-flight requests never exceed DEPTH,
  // so every response is guaranteed a FIFO slot.
  assign occupancy      = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !redirect_valid && (occupancy < OCC_MAX);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_keep = imem_resp_valid && !redirect_valid && (discard == '0);
  assign fifo_pop  = inst_valid && inst_ready && !redirect_valid;

  // Build the entry pushed for a kept response.
  always_comb begin
    push_entry      = '0;
    push_entry.pc   = resp_pc;
    push_entry.inst = imem_resp_data;
`ifdef FETCH_MISALIGN_CHK_EN
    push_entry.misalign = mis_pend;
    if (mis_pend) push_entry.inst = NOP;
`endif
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (resp_keep),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .count      (fifo_count),
    .head       (head)
  );

  // Next address to request; redirect overrides sequential advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= target_pc;
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // PC of the next response that will be kept. After a redirect every live
  // request is discarded, so the next kept word belongs to the new target.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      resp_pc <= target_pc;
    end else if (resp_keep) begin
      resp_pc <= resp_pc + 32'd4;
    end
  end

  // In-flight request count; no request issues in a redirect cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
    end
  end

  // Responses still owed to squashed requests. A redirect turns every request
  // left in flight after this cycle into a discard; already-pending discards
  // are part of that count.
  always_ff @(posedge clk) begin
    if (rst) begin
      discard <= '0;
    end else if (redirect_valid) begin
      discard <= outstanding - CNT_W'(imem_resp_valid);
    end else if (imem_resp_valid && (discard != '0)) begin
      discard <= discard - CNT_W'(1);
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  // A misaligned redirect tags the next kept entry, then clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_pend <= 1'b0;
    end else if (redirect_valid) begin
      mis_pend <= (redirect_pc[1:0] != 2'b00);
    end else if (resp_keep) begin
      mis_pend <= 1'b0;
    end
  end

  assign inst_misalign = inst_valid && head.misalign;
`endif

  // Decode sees the FIFO head; idle values are NOP at RESET_PC.
  assign inst_valid = (fifo_count != '0);
  assign inst_out   = inst_valid ? head.inst : NOP;
  assign pc_out     = inst_valid ? head.pc : RESET_PC;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: in-order variable-latency memory,
// queue-based reference model, directed scenarios then randomized traffic.
module tb_fetch_stage;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        inst_misalign;
`endif

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_out        (inst_out),
`ifdef FETCH_MISALIGN_CHK_EN
    .inst_misalign   (inst_misalign),
`endif
    .pc_out          (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[31:2], 2'b11} ^ 32'h00A0_0000;
  endfunction

  // Memory environment: in-order responses, each at least one cycle late.
  logic [31:0] mq_addr[$];
  int unsigned mq_due[$];
  int unsigned cyc = 0;
  int unsigned last_due = 0;
  int unsigned lat = 1;
  int          hs_count = 0;

  task automatic tick(input logic r, input logic rr, input logic ir,
                      input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    cyc++;
    rst            = r;
    imem_req_ready = rr;
    inst_ready     = ir;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (!r && mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  endtask

  // Reference model: queue of in-flight request PCs (with a squashed flag)
  // and queue of words buffered for decode.
  typedef struct { logic [31:0] pc; logic [31:0] inst; bit mis; } bent_t;
  typedef struct { logic [31:0] pc; bit stale; } rq_t;

  bent_t       m_buf[$];
  rq_t         m_out[$];
  logic [31:0] m_pc = 32'h0;
  bit          m_mis_pend = 1'b0;
  bit          e_req;
  bit          e_iv;
  rq_t         r_tmp;
  bent_t       b_tmp;

  // Compare DUT against the model mid-cycle, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("req_valid_in_reset", imem_req_valid, 0);
      m_buf.delete();
      m_out.delete();
      m_pc = 32'h0;
      m_mis_pend = 1'b0;
      mq_addr.delete();
      mq_due.delete();
      last_due = 0;
    end else begin
      e_req = !redirect_valid && (m_buf.size() + m_out.size() < DEPTH);
      e_iv  = (m_buf.size() != 0);
      chk("req_valid", imem_req_valid, e_req);
      if (e_req) chk("req_addr", imem_req_addr, m_pc);
      chk("inst_valid", inst_valid, e_iv);
      chk("inst_out", inst_out, e_iv ? m_buf[0].inst : NOP_W);
      chk("pc_out", pc_out, e_iv ? m_buf[0].pc : 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
      chk("inst_misalign", inst_misalign, e_iv ? m_buf[0].mis : 1'b0);
`endif
      if (imem_req_valid && imem_req_ready) begin
        hs_count++;
        mq_addr.push_back(imem_req_addr);
        last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        mq_due.push_back(last_due);
      end
      if (redirect_valid) begin
        if (imem_resp_valid && m_out.size() != 0) void'(m_out.pop_front());
        foreach (m_out[i]) m_out[i].stale = 1'b1;
        m_buf.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHK_EN
        m_mis_pend = (redirect_pc[1:0] != 2'b00);
`else
        m_mis_pend = 1'b0;
`endif
      end else begin
        if (e_iv && inst_ready) void'(m_buf.pop_front());
        if (imem_resp_valid) begin
          if (m_out.size() == 0) begin
            chk("resp_without_request", 1, 0);
          end else begin
            r_tmp = m_out.pop_front();
            if (!r_tmp.stale) begin
              b_tmp.pc   = r_tmp.pc;
              b_tmp.inst = m_mis_pend ? NOP_W : imem_resp_data;
              b_tmp.mis  = m_mis_pend;
              m_mis_pend = 1'b0;
              m_buf.push_back(b_tmp);
              chk("fifo_no_overflow", (m_buf.size() <= DEPTH), 1);
            end
          end
        end
        if (e_req && imem_req_ready) begin
          r_tmp.pc    = m_pc;
          r_tmp.stale = 1'b0;
          m_out.push_back(r_tmp);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic wait_valid(input int max, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      tick(0, 1, 1, 0, 32'h0);
      #3;
      if (inst_valid) seen = 1'b1;
    end
    chk(name, seen, 1);
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 0, 32'h0);
    tick(1, 0, 0, 0, 32'h0);
  endtask

  initial begin
    int hs0;
    logic [31:0] rpc;
    rst = 1'b1; imem_req_ready = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0;

    // Streaming with latency 1.
    lat = 1;
    do_reset();
    tick(0, 1, 1, 0, 32'h0); #3;
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_out", inst_out, 32'h0000_0013);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    tick(0, 1, 1, 0, 32'h0); #3;
    chk("second_req_addr", imem_req_addr, 32'h4);
    tick(0, 1, 1, 0, 32'h0); #3;
    chk("first_inst_valid", inst_valid, 1);
    chk("first_inst", inst_out, 32'h0050_0093);
    chk("first_pc", pc_out, 32'h0);
    tick(0, 1, 1, 0, 32'h0); #3;
    chk("second_pc", pc_out, 32'h4);

    // Decode stall: only DEPTH requests issue, then drain in order.
    do_reset();
    hs0 = hs_count;
    for (int i = 0; i < 10; i++) tick(0, 1, 0, 0, 32'h0);
    #3;
    chk("stall_requests", hs_count - hs0, 2);
    chk("stall_head_pc", pc_out, 32'h0);
    tick(0, 1, 1, 0, 32'h0); #3;
    chk("drain_pc0", pc_out, 32'h0);
    tick(0, 1, 1, 0, 32'h0); #3;
    chk("drain_pc1", pc_out, 32'h4);

    // Redirect with two requests in flight.
    lat = 4;
    do_reset();
    tick(0, 1, 1, 0, 32'h0);
    tick(0, 1, 1, 0, 32'h0);
    tick(0, 1, 1, 1, 32'h100);
    wait_valid(30, "redir_timeout");
    chk("redir_pc", pc_out, 32'h100);
    chk("redir_inst", inst_out, mem_word(32'h100));

    // Redirect coinciding with a response and a decode pop.
    lat = 1;
    do_reset();
    tick(0, 1, 1, 0, 32'h0);
    tick(0, 1, 1, 0, 32'h0);
    tick(0, 1, 1, 1, 32'h100);
    tick(0, 1, 1, 0, 32'h0); #3;
    chk("same_cycle_iv", inst_valid, 0);
    chk("same_cycle_req", imem_req_valid, 1);
    chk("same_cycle_addr", imem_req_addr, 32'h100);
    wait_valid(20, "same_cycle_timeout");
    chk("same_cycle_pc", pc_out, 32'h100);

    // Back-to-back redirects.
    lat = 2;
    do_reset();
    tick(0, 1, 1, 0, 32'h0);
    tick(0, 1, 1, 0, 32'h0);
    tick(0, 1, 1, 1, 32'h200);
    tick(0, 1, 1, 1, 32'h300);
    wait_valid(30, "b2b_timeout");
    chk("b2b_pc", pc_out, 32'h300);

    // Misaligned redirect target.
    lat = 1;
    do_reset();
    tick(0, 1, 1, 0, 32'h0);
    tick(0, 1, 1, 1, 32'h102);
    wait_valid(20, "mis_timeout");
    chk("mis_pc", pc_out, 32'h100);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis_inst", inst_out, 32'h0000_0013);
    chk("mis_flag", inst_misalign, 1);
`else
    chk("mis_inst", inst_out, mem_word(32'h100));
`endif
    wait_valid(20, "mis_next_timeout");
    chk("mis_next_pc", pc_out, 32'h104);

    // Randomized traffic, checked cycle by cycle against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 399) == 0) begin
        tick(1, 0, 0, 0, 32'h0);
      end else begin
        rpc = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0;
        tick(0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 15) == 0, rpc);
      end
    end
    tick(0, 1, 1, 0, 32'h0);
    #3;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
